// File: rtl/smg_msg_scheduler_if.sv
// ---------------------------------------------------------------------------
// smg_msg_scheduler_if
// Bundles the receive strobe/byte and the display-side outputs of the
// message scheduler.
//   rx_vld     : one-cycle pulse, a UART byte arrived
//   rx_data    : received byte, qualified by rx_vld
//   disp_data  : byte presented to the two-digit display datapath
//   disp_blank : 1 = both digits off
//   busy       : FIFO non-empty or scheduler not idle
//   level      : FIFO occupancy, 0..DEPTH
//   ovf        : one-cycle pulse, a byte was dropped on a full FIFO
// master = byte source / observer, slave = the scheduler itself.
// ---------------------------------------------------------------------------
interface smg_msg_scheduler_if;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic [7:0] disp_data;
  logic       disp_blank;
  logic       busy;
  logic [4:0] level;
  logic       ovf;

  modport master (
    output rx_vld, rx_data,
    input  disp_data, disp_blank, busy, level, ovf
  );

  modport slave (
    input  rx_vld, rx_data,
    output disp_data, disp_blank, busy, level, ovf
  );
endinterface

// File: rtl/smg_msg_scheduler.sv
// ---------------------------------------------------------------------------
// smg_msg_scheduler
// Queues received UART bytes in a small FIFO and shows them on the display
// one at a time, in arrival order: each byte is held DWELL_CYC cycles, and
// when more bytes are waiting the display is blanked GAP_CYC cycles between
// them. The last byte stays shown once the queue runs dry.
//
// Ports
//   clk   : system clock
//   rst_n : asynchronous, active-low reset
//   bus   : smg_msg_scheduler_if.slave (rx_vld/rx_data in; disp_data,
//           disp_blank, busy, level, ovf out -- all outputs registered)
//
// Parameters
//   DWELL_CYC : cycles each byte is shown        (2 .. 2^26-1)
//   GAP_CYC   : blank cycles between bytes       (1 .. 2^26-1)
//   DEPTH     : FIFO entries, power of two       (2 .. 16)
// ---------------------------------------------------------------------------
module smg_msg_scheduler #(
  parameter int unsigned DWELL_CYC = 50_000_000,
  parameter int unsigned GAP_CYC   = 5_000_000,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  smg_msg_scheduler_if.slave   bus
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [25:0] DWELL_LAST = 26'(DWELL_CYC - 1);
  localparam logic [25:0] GAP_LAST   = 26'(GAP_CYC - 1);
  localparam logic [4:0]  DEPTH_L    = 5'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // state / dwell counter
  logic [1:0]    state_q, state_d;
  logic [25:0]   cnt_q,   cnt_d;

  // FIFO
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;

  // registered outputs
  logic [7:0]    disp_q,  disp_d;
  logic          blank_q, blank_d;
  logic          busy_q,  busy_d;
  logic          ovf_q,   ovf_d;

  logic          pop, push;
  logic          fifo_empty, fifo_full;

  assign fifo_empty = (level_q == 5'd0);
  assign fifo_full  = (level_q == DEPTH_L);

  // -------------------------------------------------------------------------
  // Display sequencer. The head byte is popped on IDLE->SHOW and GAP->SHOW
  // only; a SHOW->GAP decision is made only when something is queued, so a
  // GAP always ends with a non-empty FIFO.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    blank_d = blank_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          disp_d  = mem_q[rd_ptr_q];
          blank_d = 1'b0;
          cnt_d   = 26'd0;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = 26'd0;
          if (!fifo_empty) begin
            blank_d = 1'b1;
            state_d = ST_GAP;
          end else begin
            // queue drained: leave the last byte on the display
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 26'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          pop     = 1'b1;
          disp_d  = mem_q[rd_ptr_q];
          blank_d = 1'b0;
          cnt_d   = 26'd0;
          state_d = ST_SHOW;
        end else begin
          cnt_d = cnt_q + 26'd1;
        end
      end
      default: begin
        cnt_d   = 26'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO bookkeeping. A pop in the same cycle frees a slot, so a push at
  // full is still accepted then and no overflow is flagged.
  // -------------------------------------------------------------------------
  always_comb begin
    push     = bus.rx_vld && (!fifo_full || pop);
    ovf_d    = bus.rx_vld && fifo_full && !pop;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
    busy_d = (level_d != 5'd0) || (state_d != ST_IDLE);
  end

  // Storage needs no reset: emptiness is carried by the pointers/level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 26'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 5'd0;
      disp_q   <= 8'd0;
      blank_q  <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      disp_q   <= disp_d;
      blank_q  <= blank_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.disp_data  = disp_q;
  assign bus.disp_blank = blank_q;
  assign bus.busy       = busy_q;
  assign bus.level      = level_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_smg_msg_scheduler.sv
// ---------------------------------------------------------------------------
// tb_smg_msg_scheduler
// Directed scenarios plus randomized byte traffic (with occasional resets)
// against a queue-based reference model of the display schedule.
// ---------------------------------------------------------------------------
module tb_smg_msg_scheduler;

  localparam int DWELL = 10;
  localparam int GAP   = 3;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  smg_msg_scheduler_if bus ();

  smg_msg_scheduler #(.DWELL_CYC(DWELL), .GAP_CYC(GAP), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---- reference model: queue of waiting bytes + what the display shows ----
  // m_mode: 0 idle, 1 showing, 2 blank gap; m_rem = cycles left in the phase
  logic [7:0] mq[$];
  int         m_mode;
  int         m_rem;
  logic [7:0] m_disp;
  logic       m_blank, m_ovf, m_busy;

  task automatic model_reset();
    mq.delete();
    m_mode  = 0;
    m_rem   = 0;
    m_disp  = 8'h00;
    m_blank = 1'b1;
    m_ovf   = 1'b0;
    m_busy  = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    int sz;
    bit popped;
    sz     = mq.size();
    popped = 0;
    m_ovf  = 1'b0;
    if (m_mode == 0) begin
      if (sz > 0) begin
        m_disp = mq.pop_front(); m_blank = 1'b0; m_mode = 1; m_rem = DWELL; popped = 1;
      end
    end else if (m_mode == 1) begin
      if (m_rem == 1) begin
        if (sz > 0) begin m_mode = 2; m_rem = GAP; m_blank = 1'b1; end
        else m_mode = 0;
      end else m_rem--;
    end else begin
      if (m_rem == 1) begin
        m_disp = mq.pop_front(); m_blank = 1'b0; m_mode = 1; m_rem = DWELL; popped = 1;
      end else m_rem--;
    end
    if (v) begin
      if (sz < DEPTH || popped) mq.push_back(d);
      else m_ovf = 1'b1;
    end
    m_busy = (mq.size() > 0) || (m_mode != 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Advance to the next falling edge (the rising edge in between sampled the
  // inputs currently driven), update the model, compare every output.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) model_reset();
    else        model_step(bus.rx_vld, bus.rx_data);
    chk("disp_data",  {24'd0, bus.disp_data}, {24'd0, m_disp});
    chk("disp_blank", {31'd0, bus.disp_blank}, {31'd0, m_blank});
    chk("busy",       {31'd0, bus.busy},       {31'd0, m_busy});
    chk("level",      {27'd0, bus.level},      32'(mq.size()));
    chk("ovf",        {31'd0, bus.ovf},        {31'd0, m_ovf});
    #1;
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    bus.rx_vld  = v;
    bus.rx_data = d;
    tick();
    bus.rx_vld  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [8:0] tr[$];
  logic [8:0] rk[$];
  int         rl[$];
  logic [8:0] exp_k [5];
  int         exp_l [4];
  logic [7:0] shown[$];
  logic [7:0] last;
  int         ovf_cnt, max_lvl, k, bad_show, rate;

  initial begin
    model_reset();
    rst_n       = 1'b0;
    bus.rx_vld  = 1'b0;
    bus.rx_data = 8'h00;

    // reset state, no input
    tick(); tick(); tick();
    rst_n = 1'b1;
    repeat (5) cyc(1'b0, 8'h00);
    chk("idle_blank", {31'd0, bus.disp_blank}, 32'd1);
    chk("idle_data",  {24'd0, bus.disp_data},  32'h00);
    chk("idle_busy",  {31'd0, bus.busy},       32'd0);
    chk("idle_level", {27'd0, bus.level},      32'd0);

    // single byte: visible after the second edge, held DWELL cycles
    cyc(1'b1, 8'h2A);
    chk("b1_level", {27'd0, bus.level}, 32'd1);
    chk("b1_blank", {31'd0, bus.disp_blank}, 32'd1);
    cyc(1'b0, 8'h00);
    chk("b1_data",  {24'd0, bus.disp_data}, 32'h2A);
    chk("b1_shown", {31'd0, bus.disp_blank}, 32'd0);
    repeat (DWELL - 1) cyc(1'b0, 8'h00);
    chk("b1_busy_end", {31'd0, bus.busy}, 32'd1);
    cyc(1'b0, 8'h00);
    chk("b1_busy_idle", {31'd0, bus.busy}, 32'd0);
    chk("b1_held",      {24'd0, bus.disp_data}, 32'h2A);

    // back-to-back bytes: runs of (blank,data) must be 10/3/10/3
    cyc(1'b1, 8'h01);
    cyc(1'b1, 8'h02);
    tr.push_back({bus.disp_blank, bus.disp_data});
    cyc(1'b1, 8'h03);
    tr.push_back({bus.disp_blank, bus.disp_data});
    repeat (40) begin
      cyc(1'b0, 8'h00);
      tr.push_back({bus.disp_blank, bus.disp_data});
    end
    foreach (tr[i]) begin
      if (rk.size() > 0 && rk[rk.size()-1] == tr[i]) rl[rl.size()-1]++;
      else begin rk.push_back(tr[i]); rl.push_back(1); end
    end
    exp_k = '{9'h001, 9'h101, 9'h002, 9'h102, 9'h003};
    exp_l = '{DWELL, GAP, DWELL, GAP};
    chk("b3_runs", 32'(rk.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < rk.size()) chk($sformatf("b3_run%0d_key", i), {23'd0, rk[i]}, {23'd0, exp_k[i]});
    for (int i = 0; i < 4; i++)
      if (i < rl.size()) chk($sformatf("b3_run%0d_len", i), 32'(rl[i]), 32'(exp_l[i]));
    chk("b3_final", {24'd0, bus.disp_data}, 32'h03);
    chk("b3_busy",  {31'd0, bus.busy}, 32'd0);

    // overflow: six bytes while an earlier byte is shown
    cyc(1'b1, 8'hA0);
    repeat (3) cyc(1'b0, 8'h00);
    ovf_cnt = 0; max_lvl = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'(8'h10 + i));
      if (bus.ovf) ovf_cnt++;
      if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
      if (i == 4) chk("ovf_0x14", {31'd0, bus.ovf}, 32'd1);
    end
    repeat (2) begin
      cyc(1'b0, 8'h00);
      if (bus.ovf) ovf_cnt++;
    end
    chk("ovf_pulses", 32'(ovf_cnt), 32'd2);
    chk("level_peak", 32'(max_lvl), 32'd4);
    last = 8'hA0;
    repeat (80) begin
      cyc(1'b0, 8'h00);
      if (!bus.disp_blank && bus.disp_data != last) begin
        shown.push_back(bus.disp_data);
        last = bus.disp_data;
      end
    end
    chk("ovf_shown_n", 32'(shown.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < shown.size()) chk($sformatf("ovf_shown%0d", i), {24'd0, shown[i]}, 32'(8'h10 + i));

    // push at full on the same edge as the GAP-end pop
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hB0 + i));
    k = 0;
    while (!(m_mode == 2 && m_rem == 1) && k < 100) begin cyc(1'b0, 8'h00); k++; end
    if (k >= 100) fail_now("gap_end_wait");
    chk("full_pop_lvl_pre", {27'd0, bus.level}, 32'd4);
    cyc(1'b1, 8'hC5);
    chk("full_pop_level", {27'd0, bus.level}, 32'd4);
    chk("full_pop_ovf",   {31'd0, bus.ovf},   32'd0);
    chk("full_pop_data",  {24'd0, bus.disp_data}, 32'hB1);

    // reset asserted mid-GAP with two bytes queued
    do_reset();
    cyc(1'b1, 8'hD0); cyc(1'b1, 8'hD1); cyc(1'b1, 8'hD2);
    k = 0;
    while (!(m_mode == 2 && m_rem == 2) && k < 100) begin cyc(1'b0, 8'h00); k++; end
    if (k >= 100) fail_now("mid_gap_wait");
    chk("midgap_level", {27'd0, bus.level}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_blank", {31'd0, bus.disp_blank}, 32'd1);
    chk("rst_data",  {24'd0, bus.disp_data},  32'h00);
    chk("rst_level", {27'd0, bus.level},      32'd0);
    chk("rst_busy",  {31'd0, bus.busy},       32'd0);
    tick();
    rst_n = 1'b1;
    bad_show = 0;
    repeat (40) begin
      cyc(1'b0, 8'h00);
      if (!bus.disp_blank) bad_show++;
    end
    chk("rst_no_show", 32'(bad_show), 32'd0);

    // first edge after reset release accepts a byte
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cyc(1'b1, 8'h77);
    chk("post_rst_push", {27'd0, bus.level}, 32'd1);
    cyc(1'b0, 8'h00);
    chk("post_rst_show", {24'd0, bus.disp_data}, 32'h77);

    // random traffic with varying push density and rare resets
    for (int blk = 0; blk < 12; blk++) begin
      rate = $urandom_range(1, 8);
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 599) == 0) do_reset();
        else cyc($urandom_range(0, 19) < rate, 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
